pipeline_scoreboard: RTL and testbench
======================================

PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32: architectural register count; x0 is never tracked.
REQ-002 The block SHALL have parameter NUM_UNITS, default 2: multi-cycle units, index 0 = divider, 1 = atomic.
REQ-003 The block SHALL have parameter TIMEOUT, default 64: max cycles one unit operation may stay outstanding.
REQ-004 The block SHALL have these ports (RW = $clog2(NUM_REGS)):
  clk  in  1  core clock
  reset_n  in  1  asynchronous active-low reset
  issue_valid  in  1  ID->EXE transfer accepted this cycle
  issue_mc  in  1  issuing instruction uses a multi-cycle unit
  issue_unit  in  $clog2(NUM_UNITS)  target unit index
  issue_rd  in  RW  destination register
  rs1_id, rs2_id  in  RW  source registers of the instruction in ID
  use_rs1_id, use_rs2_id  in  1  source actually read
  rd_id  in  RW  destination of the instruction in ID
  reg_write_id  in  1  instruction in ID writes rd
  mc_id, unit_id  in  1 / $clog2(NUM_UNITS)  ID instruction needs unit unit_id
  unit_done  in  NUM_UNITS  one-cycle completion pulse per unit (result written back)
  flush  in  1  pipeline redirect (branch/trap/debug)
  stall_id  out  1  hold PC and IF/ID, bubble into EXE
  pending_regs  out  NUM_REGS  registered pending-write mask
  unit_busy  out  NUM_UNITS  unit has an outstanding operation
  unit_kill  out  NUM_UNITS  one-cycle abort pulse to unit
  timeout_err  out  1  sticky watchdog error

Function
REQ-005 On issue_valid & issue_mc & issue_rd!=0 the block SHALL set pending_regs[issue_rd], set unit_busy[issue_unit], latch issue_rd in that unit's tag, and clear that unit's counter, all at the next clk edge.
REQ-006 On unit_done[u] with unit_busy[u] the block SHALL clear unit_busy[u] and pending_regs[tag_u] at the next edge; unit_done on an idle unit SHALL be ignored.
REQ-007 Same-cycle unit_done[u] and issue to unit u SHALL be legal: old tag cleared, new tag set; if both name the same register, set wins.
REQ-008 stall_id SHALL be combinational: (use_rs1_id & rs1_id!=0 & pending[rs1_id]) | (use_rs2_id & rs2_id!=0 & pending[rs2_id]) | (reg_write_id & rd_id!=0 & pending[rd_id]) | (mc_id & unit_busy[unit_id]).
REQ-009 stall_id SHALL NOT use the same-cycle unit_done bypass; dependents release one cycle after unit_done (register-file write in that cycle).
REQ-010 Issue with issue_rd==0 SHALL set unit_busy only (no pending bit); completion then clears nothing in pending_regs.
REQ-011 Issue to an already-busy unit SHALL be a protocol error; the block SHALL keep the old tag and set timeout_err.
REQ-012 Each busy unit SHALL count cycles; reaching TIMEOUT SHALL set timeout_err (sticky until reset), pulse unit_kill[u], and clear busy/pending for u.
REQ-013 flush SHALL NOT discard in-flight unit operations already issued (they are architecturally committed past EXE); flush with issue_valid same cycle SHALL suppress that issue.
REQ-014 Counter width SHALL be $clog2(TIMEOUT+1); no wrap-around is reachable.

Reset
REQ-015 reset_n low SHALL asynchronously clear pending_regs, unit_busy, tags, counters, unit_kill, timeout_err to 0; stall_id then evaluates to 0.
REQ-016 Reset mid-operation SHALL drop all outstanding state; a later unit_done SHALL be ignored per REQ-006.

Structure
REQ-017 Unit index constants (DIV_UNIT, AMO_UNIT) and NUM_UNITS default SHALL live in the shared core package.
REQ-018 One sub-module mc_unit_tracker (busy, tag, counter, kill, error for one unit) SHALL be instantiated NUM_UNITS times via generate.

Verification
REQ-019 Issue div rd=5; next cycle ID rs1=5 -> stall_id=1 until cycle after unit_done[0], pending_regs[5] 1->0.
REQ-020 Issue div rd=0 -> pending_regs stays 0, unit_busy[0]=1, no RAW stall on rs1=0.
REQ-021 unit_done[0] (tag 7) and new div issue rd=7 same cycle -> pending_regs[7]=1, unit_busy[0]=1.
REQ-022 ID holds second div while unit 0 busy -> stall_id=1; AMO to unit 1 -> not stalled.
REQ-023 Busy unit, no done for 64 cycles -> unit_kill[u] one pulse, timeout_err=1, busy/pending cleared.
REQ-024 reset_n low while div busy -> all outputs 0 immediately; subsequent unit_done ignored.

Source files
------------

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared constants for the multi-cycle unit scoreboard: unit indices, default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_scoreboard_pkg;

  localparam int NUM_REGS_DEF  = 32;
  localparam int NUM_UNITS_DEF = 2;
  localparam int TIMEOUT_DEF   = 64;

  // Multi-cycle unit indices
  localparam int DIV_UNIT = 0;
  localparam int AMO_UNIT = 1;

  // Width of an index into n items; never zero so single-unit builds still elaborate
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Bundle of issue, ID-stage query, completion and status signals of the scoreboard.
// Latency: n/a (wiring only).
// Backpressure: none; stall_id is the only hold signal and it is returned to the pipeline.
// master = pipeline side (drives issue/ID/done/flush), slave = scoreboard.
interface pipeline_scoreboard_if
  import pipeline_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_UNITS = NUM_UNITS_DEF
) ();

  localparam int RW = $clog2(NUM_REGS);
  localparam int UW = idx_w(NUM_UNITS);

  // EXE issue of a multi-cycle operation
  logic                 issue_valid;
  logic                 issue_mc;
  logic [UW-1:0]        issue_unit;
  logic [RW-1:0]        issue_rd;
  // Instruction currently sitting in ID
  logic [RW-1:0]        rs1_id;
  logic [RW-1:0]        rs2_id;
  logic                 use_rs1_id;
  logic                 use_rs2_id;
  logic [RW-1:0]        rd_id;
  logic                 reg_write_id;
  logic                 mc_id;
  logic [UW-1:0]        unit_id;
  // Completion / redirect
  logic [NUM_UNITS-1:0] unit_done;
  logic                 flush;
  // Scoreboard status
  logic                 stall_id;
  logic [NUM_REGS-1:0]  pending_regs;
  logic [NUM_UNITS-1:0] unit_busy;
  logic [NUM_UNITS-1:0] unit_kill;
  logic                 timeout_err;

  modport master (
    output issue_valid, issue_mc, issue_unit, issue_rd,
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, reg_write_id, mc_id, unit_id,
    output unit_done, flush,
    input  stall_id, pending_regs, unit_busy, unit_kill, timeout_err
  );

  modport slave (
    input  issue_valid, issue_mc, issue_unit, issue_rd,
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, reg_write_id, mc_id, unit_id,
    input  unit_done, flush,
    output stall_id, pending_regs, unit_busy, unit_kill, timeout_err
  );

endinterface

// File: rtl/pipeline_scoreboard_mc_unit_tracker.sv
// Tracks one multi-cycle unit: busy flag, destination tag, watchdog counter, kill and error.
// Latency: state updates at the next clk edge; accept/clr_vld are same-cycle combinational.
// Backpressure: none; an issue to a busy unit is rejected and flagged as an error.
// Ports: issue_vld/issue_rd (issue aimed at this unit), done (completion pulse),
//        accept/clr_vld (pending set/clear requests to the top), busy/tag/kill/err.
module mc_unit_tracker #(
  parameter int RW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issue_vld,
  input  logic [RW-1:0] issue_rd,
  input  logic          done,
  output logic          accept,
  output logic          clr_vld,
  output logic          busy,
  output logic [RW-1:0] tag,
  output logic          kill,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          fin;
  logic          timeout_hit;

  // A completion on an idle unit is a stale pulse and is ignored
  assign fin         = busy & done;
  // cnt holds (cycles busy - 1); a completion in the final cycle still wins
  assign timeout_hit = busy & ~done & (cnt == CW'(TIMEOUT - 1));
  // The unit may be re-issued in the same cycle its previous operation completes
  assign accept      = issue_vld & (~busy | done);
  assign clr_vld     = fin | timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      tag  <= '0;
      cnt  <= '0;
      kill <= 1'b0;
      err  <= 1'b0;
    end else begin
      kill <= timeout_hit;
      // Sticky: watchdog expiry or issue to a unit still holding an operation
      if (timeout_hit || (issue_vld && !accept)) begin
        err <= 1'b1;
      end
      if (accept) begin
        busy <= 1'b1;
        tag  <= issue_rd;
        cnt  <= '0;
      end else if (clr_vld) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Register/unit scoreboard for multi-cycle units (divider, atomic): RAW/WAW/structural stall.
// Latency: pending/busy update one edge after issue/done; stall_id is combinational.
// Backpressure: stall_id holds PC and IF/ID; it releases one cycle after unit_done.
// Ports: clk, reset_n (async active-low), sb (slave side of pipeline_scoreboard_if).
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_scoreboard_if.slave sb
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int UW = idx_w(NUM_UNITS);

  logic [NUM_UNITS-1:0] busy;
  logic [NUM_UNITS-1:0] kill;
  logic [NUM_UNITS-1:0] err;
  logic [NUM_UNITS-1:0] accept;
  logic [NUM_UNITS-1:0] clr_vld;
  logic [RW-1:0]        tag [NUM_UNITS];
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  clr_mask;
  logic                 issue_go;

  // A redirect in the issue cycle squashes that issue; earlier issues are already committed
  assign issue_go = sb.issue_valid & sb.issue_mc & ~sb.flush;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    mc_unit_tracker #(
      .RW      (RW),
      .TIMEOUT (TIMEOUT)
    ) u_trk (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue_vld (issue_go & (sb.issue_unit == UW'(u))),
      .issue_rd  (sb.issue_rd),
      .done      (sb.unit_done[u]),
      .accept    (accept[u]),
      .clr_vld   (clr_vld[u]),
      .busy      (busy[u]),
      .tag       (tag[u]),
      .kill      (kill[u]),
      .err       (err[u])
    );
  end

  // Clears from completing/timed-out units, sets from the accepted issue.
  // Sets are applied after clears so a same-register retire+issue stays pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (clr_vld[u]) clr_mask[tag[u]]     = 1'b1;
      if (accept[u])  set_mask[sb.issue_rd] = 1'b1;
    end
    set_mask[0] = 1'b0;  // x0 is never tracked
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // Uses registered state only: a dependent is released the cycle after unit_done,
  // when the result is in the register file.
  always_comb begin
    sb.stall_id = 1'b0;
    if (sb.use_rs1_id   && (sb.rs1_id != '0) && pending[sb.rs1_id]) sb.stall_id = 1'b1;
    if (sb.use_rs2_id   && (sb.rs2_id != '0) && pending[sb.rs2_id]) sb.stall_id = 1'b1;
    if (sb.reg_write_id && (sb.rd_id  != '0) && pending[sb.rd_id])  sb.stall_id = 1'b1;
    if (sb.mc_id && busy[sb.unit_id])                               sb.stall_id = 1'b1;
  end

  assign sb.pending_regs = pending;
  assign sb.unit_busy    = busy;
  assign sb.unit_kill    = kill;
  assign sb.timeout_err  = |err;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Testbench for pipeline_scoreboard: directed scenarios plus randomized traffic vs a reference model.
// Latency: expectations queued per cycle, compared by an independent monitor.
// Backpressure: n/a.
module tb_pipeline_scoreboard;
  import pipeline_scoreboard_pkg::*;

  localparam int NR = 32;
  localparam int NU = 2;
  localparam int TO = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_scoreboard_if #(.NUM_REGS(NR), .NUM_UNITS(NU)) sb_if ();

  pipeline_scoreboard #(.NUM_REGS(NR), .NUM_UNITS(NU), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb_if.slave)
  );

  typedef struct {
    bit iv, mc; int iu, ird;
    int rs1, rs2; bit u1, u2;
    int rdid; bit rw, mcid; int uid;
    bit [NU-1:0] done; bit fl;
  } stim_t;

  typedef struct {
    bit stall; bit [NR-1:0] pend; bit [NU-1:0] busy, kill; bit err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: per-unit occupancy with age in cycles, explicit pending set
  bit [NR-1:0] m_pend;
  bit          m_busy [NU];
  int          m_rd   [NU];
  int          m_age  [NU];
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.iv = 0; s.mc = 0; s.iu = 0; s.ird = 0;
    s.rs1 = 0; s.rs2 = 0; s.u1 = 0; s.u2 = 0;
    s.rdid = 0; s.rw = 0; s.mcid = 0; s.uid = 0;
    s.done = '0; s.fl = 0;
    return s;
  endfunction

  function automatic stim_t iss(input int unit, input int rd);
    stim_t s = nop();
    s.iv = 1; s.mc = 1; s.iu = unit; s.ird = rd;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    sb_if.issue_valid  = s.iv;
    sb_if.issue_mc     = s.mc;
    sb_if.issue_unit   = 1'(s.iu);
    sb_if.issue_rd     = RW'(s.ird);
    sb_if.rs1_id       = RW'(s.rs1);
    sb_if.rs2_id       = RW'(s.rs2);
    sb_if.use_rs1_id   = s.u1;
    sb_if.use_rs2_id   = s.u2;
    sb_if.rd_id        = RW'(s.rdid);
    sb_if.reg_write_id = s.rw;
    sb_if.mc_id        = s.mcid;
    sb_if.unit_id      = 1'(s.uid);
    sb_if.unit_done    = s.done;
    sb_if.flush        = s.fl;
  endtask

  function automatic void model_reset();
    m_pend = '0;
    m_err  = 0;
    for (int u = 0; u < NU; u++) begin
      m_busy[u] = 0; m_rd[u] = 0; m_age[u] = 0;
    end
  endfunction

  // One clock cycle: drive inputs, predict stall for this cycle and state after the edge
  task automatic cyc(input stim_t s);
    exp_t e;
    bit [NR-1:0] clr, set;
    bit [NU-1:0] kl;
    @(posedge clk); #1;
    apply(s);
    e.stall = (s.u1 && s.rs1 != 0 && m_pend[s.rs1]) ||
              (s.u2 && s.rs2 != 0 && m_pend[s.rs2]) ||
              (s.rw && s.rdid != 0 && m_pend[s.rdid]) ||
              (s.mcid && m_busy[s.uid]);
    clr = '0; set = '0; kl = '0;
    for (int u = 0; u < NU; u++) begin
      bit was, fin, go;
      was = m_busy[u];
      fin = s.done[u] && was;
      go  = s.iv && s.mc && !s.fl && (s.iu == u);
      if (fin) begin
        clr[m_rd[u]] = 1; m_busy[u] = 0;
      end else if (was && m_age[u] == TO) begin
        kl[u] = 1; m_err = 1; clr[m_rd[u]] = 1; m_busy[u] = 0;
      end else if (was) begin
        m_age[u]++;
      end
      if (go) begin
        if (was && !fin) m_err = 1;
        else begin
          m_busy[u] = 1; m_rd[u] = s.ird; m_age[u] = 1;
          if (s.ird != 0) set[s.ird] = 1;
        end
      end
    end
    m_pend = (m_pend & ~clr) | set;
    e.pend = m_pend;
    for (int u = 0; u < NU; u++) e.busy[u] = m_busy[u];
    e.kill = kl;
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(nop());
  endtask

  // Reset in the middle of a cycle; outputs must drop immediately
  task automatic do_reset();
    stim_t s = nop();
    @(posedge clk); #3;
    s.u1 = 1; s.rs1 = m_rd[0]; s.mcid = 1; s.uid = DIV_UNIT; s.done = '1;
    apply(s);
    reset_n = 1'b0;
    #1;
    chk("rst_stall",   sb_if.stall_id, 0);
    chk("rst_pending", sb_if.pending_regs, 0);
    chk("rst_busy",    sb_if.unit_busy, 0);
    chk("rst_kill",    sb_if.unit_kill, 0);
    chk("rst_err",     sb_if.timeout_err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply(nop());
    reset_n = 1'b1;
  endtask

  function automatic stim_t rnd();
    stim_t s = nop();
    int u = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0 && (!m_busy[u] || $urandom_range(0, 19) == 0)) begin
      s.iv = 1; s.mc = ($urandom_range(0, 7) != 0); s.iu = u; s.ird = $urandom_range(0, 7);
    end
    s.fl   = ($urandom_range(0, 15) == 0);
    s.rs1  = $urandom_range(0, 7); s.u1 = 1'($urandom_range(0, 1));
    s.rs2  = $urandom_range(0, 7); s.u2 = 1'($urandom_range(0, 1));
    s.rdid = $urandom_range(0, 7); s.rw = 1'($urandom_range(0, 1));
    s.mcid = 1'($urandom_range(0, 1)); s.uid = $urandom_range(0, 1);
    for (int k = 0; k < NU; k++) s.done[k] = ($urandom_range(0, 29) == 0);
    return s;
  endfunction

  // Monitor: stall sampled mid-cycle, registered state just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_id", sb_if.stall_id, e.stall);
        @(posedge clk); #1;
        chk("pending_regs", sb_if.pending_regs, e.pend);
        chk("unit_busy",    sb_if.unit_busy,    e.busy);
        chk("unit_kill",    sb_if.unit_kill,    e.kill);
        chk("timeout_err",  sb_if.timeout_err,  e.err);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    apply(nop());
    #22;
    chk("init_pending", sb_if.pending_regs, 0);
    chk("init_busy",    sb_if.unit_busy, 0);
    chk("init_err",     sb_if.timeout_err, 0);
    chk("init_stall",   sb_if.stall_id, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAW on a divider result, released the cycle after completion
    cyc(iss(DIV_UNIT, 5));
    s = nop(); s.u1 = 1; s.rs1 = 5;
    repeat (3) cyc(s);
    s.done[DIV_UNIT] = 1; cyc(s);
    s.done = '0; repeat (2) cyc(s);

    // Destination x0: busy only, no pending, no RAW on x0
    cyc(iss(DIV_UNIT, 0));
    s = nop(); s.u1 = 1; s.rs1 = 0; s.rw = 1; s.rdid = 0;
    cyc(s);
    s.done[DIV_UNIT] = 1; cyc(s);

    // Completion and re-issue of the same register in the same cycle
    cyc(iss(DIV_UNIT, 7));
    idle(2);
    s = iss(DIV_UNIT, 7); s.done[DIV_UNIT] = 1; cyc(s);
    s = nop(); s.rw = 1; s.rdid = 7; cyc(s);
    s.done[DIV_UNIT] = 1; cyc(s);

    // Structural hazard on divider only; AMO proceeds
    cyc(iss(DIV_UNIT, 3));
    s = nop(); s.mcid = 1; s.uid = DIV_UNIT; repeat (2) cyc(s);
    s = iss(AMO_UNIT, 4); s.mcid = 1; s.uid = AMO_UNIT; cyc(s);
    s = nop(); s.done = '1; cyc(s);
    idle(1);

    // Flush squashes the same-cycle issue but not an in-flight operation
    s = iss(AMO_UNIT, 9); s.fl = 1; cyc(s);
    cyc(iss(AMO_UNIT, 10));
    s = nop(); s.fl = 1; cyc(s);
    s.fl = 0; s.done[AMO_UNIT] = 1; cyc(s);

    // Watchdog expiry on the atomic unit
    cyc(iss(AMO_UNIT, 12));
    idle(TO + 3);
    do_reset();

    // Issue to a busy unit: old tag kept, error raised
    cyc(iss(DIV_UNIT, 6));
    cyc(iss(DIV_UNIT, 8));
    s = nop(); s.done[DIV_UNIT] = 1; cyc(s);
    idle(1);
    do_reset();

    // Reset with an operation in flight; later completions ignored
    cyc(iss(DIV_UNIT, 11));
    idle(2);
    do_reset();
    s = nop(); s.done = '1; s.u1 = 1; s.rs1 = 11; repeat (2) cyc(s);

    // Randomized traffic in segments separated by resets
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 400; i++) cyc(rnd());
      do_reset();
    end
    for (int i = 0; i < 300; i++) cyc(rnd());

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
